// File: rtl/actor_motion_fsm.sv
// Per-actor fixed-point motion controller: GROUND/AIR/CLIMB/STUN state machine stepped once per frame.
// Optional macro DOUBLE_JUMP_EN grants one extra mid-air jump per airborne episode.
module actor_motion_fsm #(
    parameter int ROPES       = 6,
    parameter int POS_W       = 11,
    parameter int FRAC_BITS   = 6,
    parameter int INIT_X      = 280,
    parameter int INIT_Y      = 185,
    parameter int X_MIN       = -9,
    parameter int X_MAX       = 570,
    parameter int WALK_SPEED  = 200,
    parameter int CLIMB_SPEED = 100,
    parameter int JUMP_SPEED  = 300,
    parameter int GRAVITY     = 10,
    parameter int MAX_Y_SPEED = 230,
    parameter int STUN_FRAMES = 150
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    leftPressed,
    input  logic                    rightPressed,
    input  logic                    upPressed,
    input  logic                    downPressed,
    input  logic                    onRope,
    input  logic [ROPES-1:0]        ropeCollisions,
    input  logic [ROPES-1:0][1:0]   electroStatus,
    input  logic                    onBlock,
    input  logic [3:0]              hitEdgeCode,
    input  logic signed [15:0]      platformSpeed,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic [1:0]              state,
    output logic                    stunned
);

    localparam int unsigned SPD_W = 16;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned CNT_W = (STUN_FRAMES > 1) ? $clog2(STUN_FRAMES) : 1;

    localparam logic signed [ACC_W-1:0] X_LO  = ACC_W'(X_MIN * (1 << FRAC_BITS));
    localparam logic signed [ACC_W-1:0] X_HI  = ACC_W'(X_MAX * (1 << FRAC_BITS));
    localparam logic signed [ACC_W-1:0] Y_HI  = ACC_W'((1 << (POS_W - 1 + FRAC_BITS)) - 1);
    localparam logic signed [ACC_W-1:0] Y_LO  = ACC_W'(-(1 << (POS_W - 1 + FRAC_BITS)));
    localparam logic signed [ACC_W-1:0] X_RST = ACC_W'(INIT_X * (1 << FRAC_BITS));
    localparam logic signed [ACC_W-1:0] Y_RST = ACC_W'(INIT_Y * (1 << FRAC_BITS));

    localparam logic signed [SPD_W-1:0] V_WALK  = SPD_W'(WALK_SPEED);
    localparam logic signed [SPD_W-1:0] V_CLIMB = SPD_W'(CLIMB_SPEED);
    localparam logic signed [SPD_W-1:0] V_JUMP  = -SPD_W'(JUMP_SPEED);
    localparam logic signed [SPD_W-1:0] V_GRAV  = SPD_W'(GRAVITY);
    localparam logic signed [SPD_W-1:0] V_MAXY  = SPD_W'(MAX_Y_SPEED);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_AIR    = 2'b01,
        ST_CLIMB  = 2'b10,
        ST_STUN   = 2'b11
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_x;
    logic signed [ACC_W-1:0] r_y;
    logic signed [SPD_W-1:0] r_ys;
    logic                    r_stunned;
`ifdef DOUBLE_JUMP_EN
    logic                    r_token;
    logic                    r_up_prev;
`endif

    logic [ROPES-1:0]        w_live;
    logic                    w_shock;
    logic                    w_land;
    logic signed [SPD_W-1:0] w_xs;
    logic signed [ACC_W-1:0] w_x_sum;
    logic signed [ACC_W-1:0] w_x_next;
    logic signed [SPD_W-1:0] w_ys_grav;
    logic signed [SPD_W-1:0] w_ys_air;
    logic signed [SPD_W-1:0] w_ys_climb;

    // Y integration saturated to the range the pixel output can represent
    function automatic logic signed [ACC_W-1:0] y_step(input logic signed [ACC_W-1:0] y,
                                                       input logic signed [SPD_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = y + ACC_W'(v);
        if (s > Y_HI)      y_step = Y_HI;
        else if (s < Y_LO) y_step = Y_LO;
        else               y_step = s;
    endfunction

    always_comb begin
        w_live = '0;
        for (int i = 0; i < ROPES; i++) w_live[i] = (electroStatus[i] == 2'b10);
    end

    assign w_shock = |(ropeCollisions & w_live);
    assign w_land  = onBlock & hitEdgeCode[0];

    // Carried platform speed unless exactly one unblocked direction key is held
    always_comb begin
        w_xs = platformSpeed;
        if (rightPressed && !leftPressed && !hitEdgeCode[1])     w_xs = V_WALK;
        else if (leftPressed && !rightPressed && !hitEdgeCode[3]) w_xs = -V_WALK;
    end

    always_comb begin
        w_x_sum  = r_x + ACC_W'(w_xs);
        w_x_next = w_x_sum;
        if (w_x_sum > X_HI)      w_x_next = X_HI;
        else if (w_x_sum < X_LO) w_x_next = X_LO;
    end

    always_comb begin
        w_ys_grav = r_ys + V_GRAV;
        w_ys_air  = w_ys_grav;
        if (hitEdgeCode[2] && r_ys[SPD_W-1]) w_ys_air = '0;
        else if (w_ys_grav > V_MAXY)         w_ys_air = V_MAXY;
    end

    always_comb begin
        w_ys_climb = '0;
        if (upPressed && !downPressed)      w_ys_climb = -V_CLIMB;
        else if (downPressed && !upPressed) w_ys_climb = V_CLIMB;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ST_AIR;
            r_cnt     <= '0;
            r_x       <= X_RST;
            r_y       <= Y_RST;
            r_ys      <= '0;
            r_stunned <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            r_token   <= 1'b1;
            r_up_prev <= 1'b0;
`endif
        end else if (startOfFrame) begin
`ifdef DOUBLE_JUMP_EN
            r_up_prev <= upPressed;
`endif
            if (w_shock && r_state != ST_STUN) begin
                r_state   <= ST_STUN;
                r_cnt     <= CNT_W'(STUN_FRAMES - 1);
                r_ys      <= '0;
                r_stunned <= 1'b1;
            end else begin
                case (r_state)
                    ST_STUN: begin
                        if (r_cnt == '0) begin
                            r_state   <= ST_AIR;
                            r_stunned <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_CLIMB: begin
                        r_x <= w_x_next;
                        if (!onRope) begin
                            r_state <= ST_AIR;
                            r_ys    <= w_ys_air;
                            r_y     <= y_step(r_y, w_ys_air);
                        end else begin
                            r_ys <= w_ys_climb;
                            r_y  <= y_step(r_y, w_ys_climb);
                        end
                    end
                    default: begin
                        r_x <= w_x_next;
                        if (onRope && (upPressed || downPressed)) begin
                            r_state <= ST_CLIMB;
                            r_ys    <= w_ys_climb;
                            r_y     <= y_step(r_y, w_ys_climb);
`ifdef DOUBLE_JUMP_EN
                            r_token <= 1'b1;
`endif
                        end else if (r_state == ST_GROUND) begin
                            if (upPressed) begin
                                r_state <= ST_AIR;
                                r_ys    <= V_JUMP;
                                r_y     <= y_step(r_y, V_JUMP);
                            end else if (!w_land) begin
                                r_state <= ST_AIR;
                                r_ys    <= w_ys_air;
                                r_y     <= y_step(r_y, w_ys_air);
                            end else begin
                                r_ys <= '0;
                            end
                        end else if (w_land && !r_ys[SPD_W-1]) begin
                            // Land on the platform top with the sub-pixel fraction dropped
                            r_state <= ST_GROUND;
                            r_ys    <= '0;
                            r_y     <= {r_y[ACC_W-1:FRAC_BITS], FRAC_BITS'(0)};
`ifdef DOUBLE_JUMP_EN
                            r_token <= 1'b1;
                        end else if (upPressed && !r_up_prev && r_token) begin
                            r_ys    <= V_JUMP;
                            r_y     <= y_step(r_y, V_JUMP);
                            r_token <= 1'b0;
`endif
                        end else begin
                            r_ys <= w_ys_air;
                            r_y  <= y_step(r_y, w_ys_air);
                        end
                    end
                endcase
            end
        end
    end

    assign topLeftX = POS_W'(r_x >>> FRAC_BITS);
    assign topLeftY = POS_W'(r_y >>> FRAC_BITS);
    assign state    = r_state;
    assign stunned  = r_stunned;

endmodule

// File: tb/tb_actor_motion_fsm.sv
// Directed self-checking bench for actor_motion_fsm; expected values are hand-derived with default parameters.
// Honours DOUBLE_JUMP_EN when the design is built with it.
module tb_actor_motion_fsm;

    logic              clk = 1'b0;
    logic              resetN;
    logic              sof;
    logic              left, right, up, down;
    logic              on_rope;
    logic [5:0]        rc;
    logic [5:0][1:0]   es;
    logic              on_block;
    logic [3:0]        hit;
    logic signed [15:0] ps;
    logic signed [10:0] tx, ty;
    logic [1:0]        st;
    logic              stn;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ys, exp_y, stun_frames;
    int exp_dj1, exp_dj2;

    always #5 clk = ~clk;

    actor_motion_fsm dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .leftPressed(left), .rightPressed(right), .upPressed(up), .downPressed(down),
        .onRope(on_rope), .ropeCollisions(rc), .electroStatus(es),
        .onBlock(on_block), .hitEdgeCode(hit), .platformSpeed(ps),
        .topLeftX(tx), .topLeftY(ty), .state(st), .stunned(stn)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: strobe startOfFrame across a single rising edge, return at the following falling edge
    task automatic frame();
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        sof = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
        on_rope = 1'b0; rc = '0; es = '0; on_block = 1'b0; hit = 4'b0000; ps = 16'sd0;
        do_reset();
        check("rst_x", tx, 280);
        check("rst_y", ty, 185);
        check("rst_state", st, 1);
        check("rst_stunned", stn, 0);

        // Free fall from reset: gravity accumulates to the cap
        exp_ys = 0;
        exp_y  = 185 * 64;
        for (int f = 0; f < 30; f++) begin
            frame();
            exp_ys = (exp_ys + 10 > 230) ? 230 : exp_ys + 10;
            exp_y  = exp_y + exp_ys;
            check("fall_y", ty, exp_y >>> 6);
            check("fall_state", st, 1);
        end
        check("fall_y_final", ty, 253);
        check("fall_x", tx, 280);

        // Land, jump, refuse landing while rising, then land at the apex
        do_reset();
        on_block = 1'b1; hit = 4'b0001;
        frame();
        check("land_state", st, 0);
        check("land_y", ty, 185);
        up = 1'b1;
        frame();
        check("jump_state", st, 1);
        check("jump_y", ty, 180);
        up = 1'b0;
        frame();
        check("rising_no_land_state", st, 1);
        check("rising_no_land_y", ty, 175);
        on_block = 1'b0; hit = 4'b0000;
        repeat (29) frame();
        check("apex_y", ty, 112);
        on_block = 1'b1; hit = 4'b0001;
        frame();
        check("apex_land_state", st, 0);
        check("apex_land_y", ty, 112);

        // Horizontal travel and both clamps
        ps = 16'sd18240;
        frame();
        check("carry_x", tx, 565);
        check("carry_state", st, 0);
        ps = 16'sd0; right = 1'b1;
        for (int f = 0; f < 10; f++) begin
            frame();
            check("right_clamp_x", tx, (f == 0) ? 568 : 570);
        end
        check("ground_y_steady", ty, 112);
        right = 1'b0; ps = -16'sd32768;
        frame();
        check("carry_left_x", tx, 58);
        frame();
        check("left_clamp_x", tx, -9);
        ps = 16'sd0; right = 1'b1; hit = 4'b0011;
        frame();
        check("right_blocked_x", tx, -9);

        // Both directions held: carried speed only
        left = 1'b1; hit = 4'b0001; ps = 16'sd64;
        frame();
        check("both_keys_x1", tx, -8);
        frame();
        check("both_keys_x2", tx, -7);
        frame();
        check("both_keys_x3", tx, -6);

        // Climb up a rope
        left = 1'b0; right = 1'b0; ps = 16'sd0; on_rope = 1'b1; up = 1'b1;
        frame();
        check("climb_state", st, 2);
        check("climb_y1", ty, 110);
        frame();
        check("climb_y2", ty, 108);

        // Rope touched but not live, and a live rope not touched: no shock
        rc[3] = 1'b1; es[3] = 2'b11; es[2] = 2'b10;
        frame();
        check("dead_rope_state", st, 2);
        check("dead_rope_y", ty, 107);

        // Live rope: frozen for exactly STUN_FRAMES frames, shock held throughout
        es[3] = 2'b10; right = 1'b1;
        frame();
        check("shock_state", st, 3);
        check("shock_stunned", stn, 1);
        check("shock_y", ty, 107);
        stun_frames = 1;
        for (int f = 0; f < 200; f++) begin
            frame();
            if (st != 2'b11) break;
            stun_frames++;
        end
        check("stun_len", stun_frames, 150);
        check("stun_exit_state", st, 1);
        check("stun_exit_stunned", stn, 0);
        check("stun_frozen_x", tx, -6);
        check("stun_frozen_y", ty, 107);

        // Shock beats a simultaneous landing; async reset clears the stun at once
        on_rope = 1'b0; up = 1'b0; right = 1'b0; on_block = 1'b1; hit = 4'b0001;
        frame();
        check("shock_beats_land", st, 3);
        resetN = 1'b0;
        #1;
        check("async_rst_state", st, 1);
        check("async_rst_stunned", stn, 0);
        check("async_rst_x", tx, 280);
        check("async_rst_y", ty, 185);
        rc = '0; es = '0;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        // Up edges while airborne: only honoured with the double-jump option
`ifdef DOUBLE_JUMP_EN
        exp_dj1 = 166;
        exp_dj2 = 162;
`else
        exp_dj1 = 167;
        exp_dj2 = 163;
`endif
        frame();
        check("dj_ground", st, 0);
        up = 1'b1;
        frame();
        check("dj_jump_y", ty, 180);
        up = 1'b0; on_block = 1'b0; hit = 4'b0000;
        frame();
        check("dj_rise_y", ty, 175);
        up = 1'b1;
        frame();
        check("dj_edge2_y", ty, 171);
        up = 1'b0;
        frame();
        check("dj_after_edge2_y", ty, exp_dj1);
        up = 1'b1;
        frame();
        check("dj_edge3_y", ty, exp_dj2);
        check("dj_state", st, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
